// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// IF-stage fetch engine. Owns the architectural PC, fetches 32-bit instructions
// from a variable-latency instruction memory and presents them to the IF/ID
// pipeline register. Honours hazard stalls (pc_write=0), branch redirects
// (branch_taken) and raises sticky errors on memory timeout or a misaligned
// redirect target.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   reset          asynchronous, active-low reset
//   pc_write       1 = IF/ID may accept the presented instruction
//   branch_taken   one-cycle redirect pulse (also drives flush_out)
//   branch_target  redirect address, sampled when branch_taken=1
//   imem_req       request to instruction memory (level)
//   imem_addr      address of the outstanding request
//   imem_ack       one-cycle completion strobe, imem_rdata valid with it
//   imem_rdata     fetched instruction word
//   pc_out         PC of the presented instruction
//   instruction    presented instruction, 0 when fetch_valid=0
//   fetch_valid    instruction/pc_out hold a valid fetched instruction
//   flush_out      IF/ID flush, combinational copy of branch_taken
//   imem_err       sticky: a request timed out
//   misalign_err   sticky: a redirect target was not 4-byte aligned
//   dbg_state      current FSM state, for observation only
//
// Memory handshake: imem_req is raised with imem_addr and both stay constant
// until the cycle in which imem_ack=1 (inclusive); that cycle completes the
// transfer and imem_rdata is taken on its closing edge. A request is never
// withdrawn early; the only way out without an ack is the timeout.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc_out,
    output logic [31:0] instruction,
    output logic        fetch_valid,
    output logic        flush_out,
    output logic        imem_err,
    output logic        misalign_err,
    output logic [2:0]  dbg_state
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    // S_IDLE only exists for the single cycle after reset release so that
    // imem_req stays low while reset is asserted.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_VALID = 3'd2,
        S_DRAIN = 3'd3,
        S_HANG  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [63:0]   pc, pc_nxt;
    logic [63:0]   req_addr;
    logic [CW-1:0] tmo_cnt;

    logic load_req;      // a fresh request starts next cycle at pc_nxt
    logic accept;        // capture imem_rdata into the IF/ID outputs
    logic clear_fetch;   // drop fetch_valid/instruction
    logic clear_pc_out;  // drop pc_out as well (redirect)
    logic redirect;      // branch_taken that is actually honoured
    logic timeout_hit;   // this cycle is the last one allowed without ack

    assign imem_req    = (state == S_REQ) || (state == S_DRAIN);
    assign imem_addr   = req_addr;
    assign flush_out   = branch_taken;
    assign dbg_state   = state;
    assign redirect    = branch_taken && (state != S_HANG);
    assign timeout_hit = imem_req && !imem_ack && (tmo_cnt == TMO_LAST);

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        load_req     = 1'b0;
        accept       = 1'b0;
        clear_fetch  = 1'b0;
        clear_pc_out = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                load_req  = 1'b1;
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Data belongs to the wrong path: drop it and refetch.
                        state_nxt = S_REQ;
                        load_req  = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_VALID;
                    end
                end else if (branch_taken) begin
                    // Request cannot be withdrawn; wait for its ack and discard.
                    state_nxt = S_DRAIN;
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    state_nxt = S_REQ;
                    load_req  = 1'b1;
                end else if (pc_write) begin
                    pc_nxt      = pc + 64'd4;
                    clear_fetch = 1'b1;
                    state_nxt   = S_REQ;
                    load_req    = 1'b1;
                end
            end
            S_DRAIN: begin
                // A redirect arriving together with the stale ack simply
                // retargets the fresh request; there is nothing left to drain.
                if (imem_ack) begin
                    state_nxt = S_REQ;
                    load_req  = 1'b1;
                end
            end
            S_HANG: begin
                state_nxt = S_HANG;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Redirect overrides the PC in every live state.
        if (redirect) begin
            pc_nxt       = {branch_target[63:2], 2'b00};
            clear_fetch  = 1'b1;
            clear_pc_out = 1'b1;
        end

        // A dead memory ends everything, even a redirect in the same cycle.
        if (timeout_hit) begin
            state_nxt = S_HANG;
            load_req  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State, PC and request address
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= 64'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_req) begin
                req_addr <= pc_nxt;
            end
        end
    end

    // Counts consecutive unacknowledged request cycles (REQ and DRAIN alike).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (timeout_hit || !imem_req || imem_ack) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID-facing outputs and sticky errors
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out       <= 64'h0;
            instruction  <= 32'h0;
            fetch_valid  <= 1'b0;
            imem_err     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (accept) begin
                instruction <= imem_rdata;
                pc_out      <= req_addr;
                fetch_valid <= 1'b1;
            end
            if (clear_fetch) begin
                instruction <= 32'h0;
                fetch_valid <= 1'b0;
            end
            if (clear_pc_out) begin
                pc_out <= 64'h0;
            end
            if (redirect && (branch_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            if (timeout_hit) begin
                imem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int          TB_TIMEOUT = 15;
  localparam logic [63:0] TB_RESET_PC = 64'h0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [63:0] pc_out;
  logic [31:0] instruction;
  logic        fetch_valid;
  logic        flush_out;
  logic        imem_err;
  logic        misalign_err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(TB_RESET_PC), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instruction(instruction), .fetch_valid(fetch_valid), .flush_out(flush_out),
    .imem_err(imem_err), .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00A00093;
    return (a[31:0] * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; pc_write = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are checked 1ns later.
  task automatic step(input logic pw, input logic br, input logic [63:0] tgt,
                      input logic ack, input logic [31:0] rd);
    @(negedge clk);
    pc_write = pw; branch_taken = br; branch_target = tgt;
    imem_ack = ack; imem_rdata = rd;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (one row per cycle, starting right after reset)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        pw;
    logic        br;
    logic [63:0] tgt;
    logic        ack;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_fv;
    logic [63:0] e_pc_out;
    logic [31:0] e_instr;
    logic        e_merr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_row(input logic pw, input logic br, input logic [63:0] tgt,
                         input logic ack, input logic e_req, input logic [63:0] e_addr,
                         input logic e_fv, input logic [63:0] e_pc_out,
                         input logic [31:0] e_instr, input logic e_merr);
    vec_t v;
    v.pw = pw; v.br = br; v.tgt = tgt; v.ack = ack; v.e_req = e_req; v.e_addr = e_addr;
    v.e_fv = e_fv; v.e_pc_out = e_pc_out; v.e_instr = e_instr; v.e_merr = e_merr;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model (transaction view: what is on the bus, what is
  // being presented, where the program counter points)
  // ---------------------------------------------------------------------------
  logic        m_boot, m_busy, m_stale, m_hold, m_hang, m_ierr, m_merr;
  logic [63:0] m_pc, m_addr, m_pc_out;
  logic [31:0] m_instr;
  int          m_wait;

  task automatic model_reset();
    m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_hang = 1'b0;
    m_ierr = 1'b0; m_merr = 1'b0; m_pc = TB_RESET_PC; m_addr = 64'h0;
    m_pc_out = 64'h0; m_instr = 32'h0; m_wait = 0;
  endtask

  task automatic model_step(input logic pw, input logic br, input logic [63:0] tgt,
                            input logic ack, input logic [31:0] rd);
    logic start_fetch, was_holding, timed_out;
    if (m_hang) return;
    start_fetch = 1'b0;
    was_holding = m_hold;
    timed_out   = m_busy && !ack && (m_wait + 1 == TB_TIMEOUT);
    m_wait      = (m_busy && !ack) ? m_wait + 1 : 0;
    if (m_boot) begin
      m_boot = 1'b0;
      start_fetch = 1'b1;
    end
    if (m_busy && ack) begin
      m_busy = 1'b0;
      if (m_stale || br) start_fetch = 1'b1;
      else begin
        m_hold = 1'b1; m_instr = rd; m_pc_out = m_addr;
      end
      m_stale = 1'b0;
    end
    if (br) begin
      m_pc = {tgt[63:2], 2'b00};
      if (tgt[1:0] != 2'b00) m_merr = 1'b1;
      m_hold = 1'b0; m_instr = 32'h0; m_pc_out = 64'h0;
      if (m_busy) m_stale = 1'b1;
      else start_fetch = 1'b1;
    end else if (was_holding && pw) begin
      m_pc = m_pc + 64'd4;
      m_hold = 1'b0; m_instr = 32'h0;
      start_fetch = 1'b1;
    end
    if (timed_out) begin
      m_hang = 1'b1; m_busy = 1'b0; m_ierr = 1'b1; m_wait = 0; start_fetch = 1'b0;
    end
    if (start_fetch) begin
      m_busy = 1'b1; m_addr = m_pc;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic        pw, br, ack, busy0;
    logic [63:0] tgt;
    logic [31:0] rd;
    int          r_cnt, r_lat;

    // Table: zero-wait memory, addresses 0,4,8,12, then a misaligned redirect
    // to 0x102 while the request at 16 is pending.
    //      pw br tgt     ack req addr     fv pc_out   instr             merr
    add_row(1, 0, 64'h0,   0, 0, 64'h0,   0, 64'h0,   32'h0,            0);
    add_row(1, 0, 64'h0,   1, 1, 64'h0,   0, 64'h0,   32'h0,            0);
    add_row(1, 0, 64'h0,   0, 0, 64'h0,   1, 64'h0,   mem_word(64'h0),  0);
    add_row(1, 0, 64'h0,   1, 1, 64'h4,   0, 64'h0,   32'h0,            0);
    add_row(1, 0, 64'h0,   0, 0, 64'h0,   1, 64'h4,   mem_word(64'h4),  0);
    add_row(1, 0, 64'h0,   1, 1, 64'h8,   0, 64'h4,   32'h0,            0);
    add_row(1, 0, 64'h0,   0, 0, 64'h0,   1, 64'h8,   mem_word(64'h8),  0);
    add_row(1, 0, 64'h0,   1, 1, 64'hC,   0, 64'h8,   32'h0,            0);
    add_row(1, 0, 64'h0,   0, 0, 64'h0,   1, 64'hC,   mem_word(64'hC),  0);
    add_row(1, 1, 64'h102, 0, 1, 64'h10,  0, 64'hC,   32'h0,            0);
    add_row(1, 0, 64'h0,   1, 1, 64'h10,  0, 64'h0,   32'h0,            1);
    add_row(1, 0, 64'h0,   1, 1, 64'h100, 0, 64'h0,   32'h0,            1);
    add_row(0, 0, 64'h0,   0, 0, 64'h0,   1, 64'h100, mem_word(64'h100), 1);
    add_row(0, 0, 64'h0,   0, 0, 64'h0,   1, 64'h100, mem_word(64'h100), 1);
    add_row(1, 0, 64'h0,   0, 0, 64'h0,   1, 64'h100, mem_word(64'h100), 1);
    add_row(1, 0, 64'h0,   0, 1, 64'h104, 0, 64'h100, 32'h0,            1);

    // Reset state, checked while reset is still asserted.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_imem_req", 64'(imem_req), 64'h0);
    chk("reset_fetch_valid", 64'(fetch_valid), 64'h0);
    chk("reset_pc_out", pc_out, 64'h0);
    chk("reset_instruction", 64'(instruction), 64'h0);
    chk("reset_imem_err", 64'(imem_err), 64'h0);
    chk("reset_misalign_err", 64'(misalign_err), 64'h0);

    // ---- table-driven vectors ----
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].pw, vecs[i].br, vecs[i].tgt, vecs[i].ack,
           vecs[i].ack ? mem_word(vecs[i].e_addr) : 32'h0);
      chk($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("tbl%0d_fv", i), 64'(fetch_valid), 64'(vecs[i].e_fv));
      chk($sformatf("tbl%0d_pc_out", i), pc_out, vecs[i].e_pc_out);
      chk($sformatf("tbl%0d_instr", i), 64'(instruction), 64'(vecs[i].e_instr));
      chk($sformatf("tbl%0d_flush", i), 64'(flush_out), 64'(vecs[i].br));
      chk($sformatf("tbl%0d_merr", i), 64'(misalign_err), 64'(vecs[i].e_merr));
    end

    // ---- 3-cycle ack latency, stall hold, redirect into DRAIN ----
    do_reset();
    step(1, 0, 64'h0, 0, 32'h0);
    chk("lat_boot_req", 64'(imem_req), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 64'h0, (i == 2), (i == 2) ? 32'h00A00093 : 32'h0);
      chk($sformatf("lat_req_c%0d", i), 64'(imem_req), 64'h1);
      chk($sformatf("lat_addr_c%0d", i), imem_addr, 64'h0);
      chk($sformatf("lat_fv_c%0d", i), 64'(fetch_valid), 64'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 64'h0, 0, 32'h0);
      chk($sformatf("stall_req_c%0d", i), 64'(imem_req), 64'h0);
      chk($sformatf("stall_fv_c%0d", i), 64'(fetch_valid), 64'h1);
      chk($sformatf("stall_instr_c%0d", i), 64'(instruction), 64'h00A00093);
      chk($sformatf("stall_pc_out_c%0d", i), pc_out, 64'h0);
    end
    step(1, 0, 64'h0, 0, 32'h0);
    chk("release_fv", 64'(fetch_valid), 64'h1);
    step(0, 0, 64'h0, 1, mem_word(64'h4));
    chk("release_req", 64'(imem_req), 64'h1);
    chk("release_addr", imem_addr, 64'h4);
    step(1, 0, 64'h0, 0, 32'h0);
    chk("pc4_fv", 64'(fetch_valid), 64'h1);
    chk("pc4_pc_out", pc_out, 64'h4);
    step(1, 0, 64'h0, 0, 32'h0);
    chk("pend8_addr", imem_addr, 64'h8);
    step(1, 1, 64'h100, 0, 32'h0);
    chk("redir_flush", 64'(flush_out), 64'h1);
    chk("redir_req", 64'(imem_req), 64'h1);
    step(1, 0, 64'h0, 1, mem_word(64'h8));
    chk("drain_req", 64'(imem_req), 64'h1);
    chk("drain_addr", imem_addr, 64'h8);
    chk("drain_flush", 64'(flush_out), 64'h0);
    chk("drain_fv", 64'(fetch_valid), 64'h0);
    step(1, 0, 64'h0, 1, mem_word(64'h100));
    chk("after_drain_fv", 64'(fetch_valid), 64'h0);
    chk("after_drain_addr", imem_addr, 64'h100);
    chk("after_drain_merr", 64'(misalign_err), 64'h0);
    step(0, 0, 64'h0, 0, 32'h0);
    chk("tgt_fv", 64'(fetch_valid), 64'h1);
    chk("tgt_pc_out", pc_out, 64'h100);
    chk("tgt_instr", 64'(instruction), 64'(mem_word(64'h100)));

    // ---- timeout into HANG, then reset recovers ----
    do_reset();
    step(1, 0, 64'h0, 0, 32'h0);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      step(1, 0, 64'h0, 0, 32'h0);
      chk($sformatf("tmo_req_c%0d", i), 64'(imem_req), 64'h1);
      chk($sformatf("tmo_err_c%0d", i), 64'(imem_err), 64'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 64'h0, 0, 32'h0);
      chk($sformatf("hang_req_c%0d", i), 64'(imem_req), 64'h0);
      chk($sformatf("hang_err_c%0d", i), 64'(imem_err), 64'h1);
      chk($sformatf("hang_fv_c%0d", i), 64'(fetch_valid), 64'h0);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("hang_rst_err", 64'(imem_err), 64'h0);
    chk("hang_rst_req", 64'(imem_req), 64'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    step(1, 0, 64'h0, 0, 32'h0);
    chk("restart_boot_req", 64'(imem_req), 64'h0);
    step(1, 0, 64'h0, 0, 32'h0);
    chk("restart_req", 64'(imem_req), 64'h1);
    chk("restart_addr", imem_addr, TB_RESET_PC);

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    r_cnt = 0;
    r_lat = $urandom_range(1, 4);
    for (int c = 0; c < 800; c++) begin
      pw  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0);
      tgt = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      busy0 = m_busy;
      ack   = m_busy && (r_cnt + 1 >= r_lat);
      rd    = ack ? mem_word(m_addr) : $urandom;
      step(pw, br, tgt, ack, rd);
      chk($sformatf("rnd%0d_req", c), 64'(imem_req), 64'(m_busy));
      if (m_busy) chk($sformatf("rnd%0d_addr", c), imem_addr, m_addr);
      chk($sformatf("rnd%0d_fv", c), 64'(fetch_valid), 64'(m_hold));
      chk($sformatf("rnd%0d_instr", c), 64'(instruction), 64'(m_instr));
      chk($sformatf("rnd%0d_pc_out", c), pc_out, m_pc_out);
      chk($sformatf("rnd%0d_flush", c), 64'(flush_out), 64'(br));
      chk($sformatf("rnd%0d_merr", c), 64'(misalign_err), 64'(m_merr));
      chk($sformatf("rnd%0d_ierr", c), 64'(imem_err), 64'(m_ierr));
      model_step(pw, br, tgt, ack, rd);
      if (ack) begin
        r_cnt = 0;
        r_lat = $urandom_range(1, 4);
      end else if (busy0) r_cnt++;
      else r_cnt = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
